// File: rtl/store_buffer.sv
// Posted-write store buffer: in-order drain to data memory when the core is not
// loading, with youngest-match store-to-load forwarding.
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         st_valid,
    input  logic [AW-1:0]                st_addr,
    input  logic [DW-1:0]                st_data,
    output logic                         st_ready,
    input  logic                         ld_valid,
    input  logic [AW-1:0]                ld_addr,
    output logic [DW-1:0]                ld_data,
    output logic                         ld_fwd,
    output logic                         mem_we,
    output logic [AW-1:0]                mem_addr,
    output logic [DW-1:0]                mem_wd,
    input  logic [DW-1:0]                mem_rd,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [AW-1:0]    r_addr [DEPTH];
    logic [DW-1:0]    r_data [DEPTH];
    logic [DEPTH-1:0] r_valid;
    logic [PW-1:0]    r_head;
    logic [PW-1:0]    r_tail;
    logic [CW-1:0]    r_count;

    logic             w_push;
    logic             w_pop;
    logic             w_fwd_hit;
    logic [DW-1:0]    w_fwd_data;
    logic [PW-1:0]    w_idx;

    assign st_ready = (r_count != CW'(DEPTH));
    assign empty    = (r_count == '0);
    assign count    = r_count;
    assign w_push   = st_valid && st_ready;
    assign w_pop    = rst_n && !ld_valid && (r_count != '0);

    // Port arbitration; held at zero during reset so nothing reaches memory.
    always_comb begin
        mem_we   = 1'b0;
        mem_addr = '0;
        mem_wd   = '0;
        if (rst_n) begin
            if (ld_valid) begin
                mem_addr = ld_addr;
            end else if (r_count != '0) begin
                mem_we   = 1'b1;
                mem_addr = r_addr[r_head];
                mem_wd   = r_data[r_head];
            end
        end
    end

    // Walk oldest to youngest so the last hit is the youngest matching store.
    always_comb begin
        w_fwd_hit  = 1'b0;
        w_fwd_data = '0;
        w_idx      = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_idx = r_head + PW'(k);
            if (r_valid[w_idx] && (r_addr[w_idx][AW-1:2] == ld_addr[AW-1:2])) begin
                w_fwd_hit  = 1'b1;
                w_fwd_data = r_data[w_idx];
            end
        end
    end

    assign ld_fwd  = w_fwd_hit;
    assign ld_data = w_fwd_hit ? w_fwd_data : mem_rd;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_valid <= '0;
        end else begin
            if (w_push) begin
                r_valid[r_tail] <= 1'b1;
                r_tail          <= r_tail + 1'b1;
            end
            if (w_pop) begin
                r_valid[r_head] <= 1'b0;
                r_head          <= r_head + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Payload storage needs no reset; the valid bits qualify it.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_addr[r_tail] <= st_addr;
            r_data[r_tail] <= st_data;
        end
    end

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Posted-write FIFO between the core's load/store path and the byte-addressed data memory.
- Accepts word stores in one cycle, then drains them to memory in order, one per cycle, whenever the core is not loading.
- Loads get memory data, or the youngest matching buffered store when one exists (store-to-load forwarding).
- Owns the memory's single address port: multiplexes load reads and drain writes onto mem_we/mem_addr/mem_wd.

Parameters:
- DEPTH, 4, number of buffered stores; power of two, at least 2.
- AW, 32, address width.
- DW, 32, data width; word size is 4 bytes.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- st_valid  in  1  core presents a store this cycle.
- st_addr  in  AW  store byte address; word-aligned.
- st_data  in  DW  store data.
- st_ready  out  1  buffer can accept a store; core stalls while low.
- ld_valid  in  1  core performs a load this cycle.
- ld_addr  in  AW  load byte address; word-aligned.
- ld_data  out  DW  load result, combinational.
- ld_fwd  out  1  ld_data came from the buffer rather than memory.
- mem_we  out  1  memory write enable.
- mem_addr  out  AW  memory byte address.
- mem_wd  out  DW  memory write data.
- mem_rd  in  DW  memory read data, combinational from mem_addr.
- empty  out  1  no buffered stores.
- count  out  $clog2(DEPTH+1)  number of buffered stores.

Behaviour:
- Storage: circular FIFO with head/tail pointers, a count register, and a per-entry address, data and valid bit.
- Reset (asynchronous, rst_n low): pointers=0, count=0, all valid bits=0.
  - Outputs while in reset: st_ready=1, empty=1, mem_we=0, mem_addr=0, mem_wd=0, ld_fwd=0.
  - Stores pending when reset asserts are discarded, including mid-drain; no partial write follows.
- st_ready = (count != DEPTH). It depends only on registered state, never on a same-cycle pop.
- Push: when st_valid && st_ready, the entry is written at the tail on the rising edge and tail increments modulo DEPTH.
  - st_valid while st_ready=0 is ignored; the core holds the store.
- Port arbitration, combinational, loads have priority:
  - ld_valid=1: mem_we=0, mem_addr=ld_addr, mem_wd=0.
  - else count>0: mem_we=1, mem_addr=head addr, mem_wd=head data; the head pops on this edge and head increments modulo DEPTH.
  - else: mem_we=0, mem_addr=0, mem_wd=0.
- Latency: a store pushed at edge N drives mem_we no earlier than the cycle after edge N and reaches memory at edge N+1 at the earliest. There is no same-cycle passthrough to memory.
- Push and pop on the same edge: count unchanged, FIFO order preserved. This is legal at count=DEPTH-1 or below; at count=DEPTH, st_ready=0 blocks the push.
- Forwarding:
  - Compare ld_addr[AW-1:2] against the addresses of all valid entries.
  - On any match: ld_data = data of the youngest matching entry (closest to tail), ld_fwd=1.
  - Otherwise: ld_data = mem_rd, ld_fwd=0.
  - A store being pushed in the same cycle is not visible to a load in that cycle.
- Byte offset addr[1:0] is ignored for compare and passed unchanged to memory. The core issues only aligned word accesses.
- Stores are not merged: repeated stores to one address each occupy an entry and each drains.
- Continuous loads hold off draining indefinitely. The core guarantees a load-free cycle eventually, so there is no forced drain.
- empty = (count==0). count is registered.
- Pointer wrap: head and tail wrap from DEPTH-1 to 0; full versus empty is distinguished by count, not pointer equality.

Test Plan:
- Reset: assert rst_n=0 mid-cycle, no clock edge -> st_ready=1, empty=1, count=0, mem_we=0 immediately.
- Single store: st 0x10/0xDEADBEEF, ld_valid=0 -> next cycle mem_we=1, mem_addr=0x10, mem_wd=0xDEADBEEF; following cycle empty=1, mem_we=0.
- Fill under load pressure: ld_valid=1 held, four stores 0x00,0x04,0x08,0x0C -> count=4, st_ready=0, mem_we=0; fifth store is held.
  - Then drop ld_valid -> four writes on consecutive cycles in order 0x00..0x0C, after which st_ready=1.
- Forwarding: with ld_valid held, stores 0x20/0x1111 then 0x20/0x2222.
  - Load 0x20 -> ld_data=0x2222, ld_fwd=1.
  - Load 0x24 with mem_rd=0xCAFE -> ld_data=0xCAFE, ld_fwd=0.
- Simultaneous push/pop at count=2, ld_valid=0, new store 0x40 -> count stays 2, head written to memory, 0x40 drains last; cover pointer wrap past DEPTH-1.
- Reset mid-drain: count=3, assert rst_n=0 -> count=0, empty=1.
  - After release, no mem_we pulses occur and a load to a previously buffered address returns mem_rd with ld_fwd=0.
